// File: rtl/array_divider_9x5_pkg.sv
// Shared widths, counter sizing and FSM encoding for the 9/5 restoring divider.
// Optional feature macro used by the design: DIV_ZERO_FLAG_EN.
package array_div_pkg;

  localparam int unsigned DIVIDEND_W = 9;
  localparam int unsigned DIVISOR_W  = 5;
  localparam int unsigned CNT_W      = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/array_divider_9x5_if.sv
// Start/busy/done handshake and operand/result bundle for array_divider_9x5.
// DIV_ZERO_FLAG_EN adds the div_by_zero result flag.
interface array_divider_9x5_if;
  import array_div_pkg::*;

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;

`ifdef DIV_ZERO_FLAG_EN
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder
  );
`endif

endinterface

// File: rtl/array_divider_9x5_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
// Independent of DIV_ZERO_FLAG_EN.
module div_step
  import array_div_pkg::*;
(
  input  logic [DIVISOR_W:0]   p_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   p_o,
  output logic                 q_o
);

  localparam int unsigned SW = DIVISOR_W + 2;

  logic [SW-1:0] shifted;
  logic [SW-1:0] dvs_ext;

  // P < divisor between steps keeps the difference inside DIVISOR_W+1 bits
  assign shifted = {p_i, bit_i};
  assign dvs_ext = SW'(divisor_i);
  assign q_o     = (shifted >= dvs_ext);
  assign p_o     = q_o ? (DIVISOR_W+1)'(shifted - dvs_ext) : shifted[DIVISOR_W:0];

endmodule

// File: rtl/array_divider_9x5_dreg.sv
// Load-enabled result register with synchronous active-high clear.
// Independent of DIV_ZERO_FLAG_EN; width chosen by the instantiating block.
module DReg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/array_divider_9x5.sv
// Sequential restoring divider, 9-bit dividend by 5-bit divisor, one quotient bit per clock.
// DIV_ZERO_FLAG_EN: zero divisor short-circuits to DONE and raises div_by_zero.
module array_divider_9x5
  import array_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  array_divider_9x5_if.slave   bus
);

`ifdef DIV_ZERO_FLAG_EN
  localparam int unsigned OUT_W = DIVIDEND_W + DIVISOR_W + 1;
`else
  localparam int unsigned OUT_W = DIVIDEND_W + DIVISOR_W;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W:0]    p_q, p_d, p_step;
  logic                  q_bit;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  out_en;
  logic [OUT_W-1:0]      out_d, out_q;

  // dvd_q shifts dividend bits out of the top and quotient bits in at the bottom
  div_step u_step (
    .p_i       (p_q),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dvs_q),
    .p_o       (p_step),
    .q_o       (q_bit)
  );

  DReg #(.WIDTH(OUT_W)) u_out (
    .clk  (clk),
    .rst  (rst),
    .en_i (out_en),
    .d_i  (out_d),
    .q_o  (out_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    out_en  = 1'b0;
    out_d   = out_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          dvd_d = bus.dividend;
          dvs_d = bus.divisor;
          p_d   = '0;
          cnt_d = '0;
`ifdef DIV_ZERO_FLAG_EN
          if (bus.divisor == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            out_en  = 1'b1;
            out_d   = {{DIVIDEND_W{1'b1}}, bus.dividend[DIVISOR_W-1:0], 1'b1};
          end else begin
            // Result fields hold; only the flag clears on a new operation
            state_d = RUN;
            busy_d  = 1'b1;
            out_en  = 1'b1;
            out_d   = {out_q[OUT_W-1:1], 1'b0};
          end
`else
          state_d = RUN;
          busy_d  = 1'b1;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        busy_d = 1'b1;
        p_d    = p_step;
        dvd_d  = {dvd_q[DIVIDEND_W-2:0], q_bit};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          out_en  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
          out_d   = {dvd_d, p_step[DIVISOR_W-1:0], 1'b0};
`else
          out_d   = {dvd_d, p_step[DIVISOR_W-1:0]};
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = out_q[OUT_W-1 -: DIVIDEND_W];
  assign bus.remainder = out_q[OUT_W-DIVIDEND_W-1 -: DIVISOR_W];
`ifdef DIV_ZERO_FLAG_EN
  assign bus.div_by_zero = out_q[0];
`endif

endmodule

// File: doc/array_divider_9x5.md
# array_divider_9x5

Sequential restoring divider that inverts the 4x5 array multiplier. It divides a 9-bit dividend (multiplier product width) by a 5-bit divisor and returns a 9-bit quotient and a 5-bit remainder. It is used to recover an operand from a product and to self-check the multiplier datapath. It retires one quotient bit per clock behind a start/busy/done handshake.

## Interface
- DIVIDEND_W, 9, dividend and quotient width; also the iteration count
- DIVISOR_W, 5, divisor and remainder width
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- dividend  input  DIVIDEND_W  numerator; latched on accepted start
- divisor  input  DIVISOR_W  denominator; latched on accepted start
- busy  output  1  iteration in progress; reset 0
- done  output  1  one-cycle result-valid pulse; reset 0
- quotient  output  DIVIDEND_W  result; held until next done; reset 0
- remainder  output  DIVISOR_W  result; held until next done; reset 0
- div_by_zero  output  1  present only with DIV_ZERO_FLAG_EN; reset 0

## Operation
- FSM states: IDLE, RUN, DONE. Reset forces IDLE, count=0, and clears all outputs and internal registers.
- IDLE or DONE, with start=1: latch dividend and divisor, clear the partial remainder P (DIVISOR_W+1 bits), set count=0, go to RUN.
- IDLE or DONE, with start=0: go to (or stay in) IDLE.
- RUN, one step per cycle, MSB first:
  - P' = {P[DIVISOR_W-1:0], next dividend bit}.
  - If P' ≥ divisor: P = P' − divisor and the quotient bit is 1. Otherwise P = P' and the quotient bit is 0.
- After step DIVIDEND_W (count = DIVIDEND_W−1): load quotient and remainder = P[DIVISOR_W-1:0], then go to DONE.
- busy=1 only in RUN. done=1 only in DONE.
- start and operand inputs are ignored while busy=1. Changes during RUN do not affect the result.
- Arithmetic is unsigned. Invariant for divisor≠0: quotient·divisor + remainder = dividend, with remainder < divisor.
- Divisor=0 without the macro: the iterations run normally. Result is quotient=9'h1FF, remainder=dividend[4:0].
- Reset mid-operation: on the next edge, state is IDLE, busy=0, done=0, quotient=0, remainder=0. The aborted operation produces no done pulse.

## Timing
- start sampled at edge t → busy=1 from t+1 through t+9.
- Result registered at edge t+9. done=1 and quotient/remainder are valid during the cycle after edge t+9.
- Latency: 9 cycles from accepted start to done.
- Back-to-back: start=1 during the DONE cycle is accepted at edge t+10. The next done pulse follows at t+19.
- quotient and remainder stay stable between done pulses. They update only at the edge that raises done.

## Configuration
- Macro: DIV_ZERO_FLAG_EN.
- Defined:
  - div_by_zero port exists.
  - Accepted start with divisor=0 goes directly to DONE at the next edge, with no RUN cycles.
  - Outputs: quotient=9'h1FF, remainder=dividend[4:0], div_by_zero=1.
  - div_by_zero stays valid with the result and clears on the next accepted start.
- Undefined: port absent. Divisor=0 takes the full 9-cycle path with the same quotient/remainder values.

## Structure
- Package array_div_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default widths DIVIDEND_W=9 and DIVISOR_W=5;
  - count width $clog2(DIVIDEND_W).
- Sub-module div_step: combinational single restoring step. Inputs are P, the incoming dividend bit and the divisor. Outputs are next P and the quotient bit. Instantiated once.
- Output register: the team's existing DReg, WIDTH = DIVIDEND_W + DIVISOR_W (+1 with the macro), with load enabled on the RUN→DONE transition.

## Test plan
- Exact quotient: dividend=60, divisor=5 → done 9 cycles after start; quotient=12, remainder=0; busy high for exactly 9 cycles.
- Maximum operands: dividend=511, divisor=31 → quotient=16, remainder=15. Also dividend=7, divisor=9 → quotient=0, remainder=7.
- Multiplier round-trip: for all x in 0..15 and y in 1..31, dividend=x·y, divisor=y → quotient=x, remainder=0.
- Divide by zero: dividend=9'h0AB, divisor=0. With DIV_ZERO_FLAG_EN → done one cycle after start, quotient=9'h1FF, remainder=5'h0B, div_by_zero=1. Without the macro → done after 9 cycles, same quotient and remainder.
- Reset mid-operation: assert rst during the 4th RUN cycle → next cycle busy=0, done=0, quotient=0, remainder=0, no done pulse. A subsequent 100/7 → quotient=14, remainder=2.
- Handshake:
  - start pulsed during RUN with different operands → ignored; the original result is delivered.
  - start held during DONE → accepted; the second done follows 10 cycles after the first.
